qupls_decode_seq: RTL and testbench

Decode-window sequencer between the fetch/predecode queue and the instruction decoder. It buffers predecoded instruction words in a small FIFO and assembles each instruction plus up to five trailing postfix words into the six-entry window the decoder consumes. It issues one window per cycle with a one-cycle decoder enable, and drops orphan postfix words.

---
 rtl/qupls_decode_seq_pkg.sv | 19 +
 rtl/qupls_decode_seq_scan.sv | 35 +++
 rtl/qupls_decode_seq.sv | 194 +++++++++++++++++++
 tb/tb_qupls_decode_seq.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/qupls_decode_seq_pkg.sv
// Shared types for the decode-window sequencer: instruction word, NOP filler and FSM states.
package QuplsPkg;

    typedef struct packed {
        logic [7:0]  opcode;
        logic [23:0] imm;
    } ex_instruction_t;

    localparam ex_instruction_t QUPLS_NOP_EXINS = '{opcode: 8'hEA, imm: 24'h0};

    localparam int QUPLS_WIN = 6;

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_GATHER = 2'd1,
        S_HOLD   = 2'd2
    } decseq_state_t;

endpackage

// File: rtl/qupls_decode_seq_scan.sv
// Combinational window scan over the six FIFO entries at the head: postfix run length,
// window-complete and orphan-head detection.
module qupls_decode_seq_scan
    import QuplsPkg::*;
#(
    parameter int CW      = 4,
    parameter int MAX_PFX = 5
) (
    input  logic [QUPLS_WIN-1:0] pfx,
    input  logic [CW-1:0]        count,
    input  logic                 in_idle,
    output logic [2:0]           n,
    output logic                 complete,
    output logic                 orphan
);

    logic          run;
    logic [CW-1:0] win_len;

    always_comb begin
        n   = '0;
        run = 1'b1;
        for (int j = 1; j <= MAX_PFX; j++) begin
            run = run && (CW'(j) < count) && pfx[j];
            if (run) n = 3'(j);
        end
        win_len = CW'(n) + CW'(1);
        orphan  = (count != '0) && pfx[0];
        // count > n+1 means the entry after the run exists and is not a postfix
        complete = (count != '0) && !pfx[0] &&
                   ((count > win_len) || (n == 3'(MAX_PFX)) ||
                    (in_idle && (count == win_len)));
    end

endmodule

// File: rtl/qupls_decode_seq.sv
// Decode-window sequencer: FIFO of predecoded words, assembles instruction + postfix windows.
// Optional QUPLS_DECSEQ_STATS_EN adds stat_issued / stat_stall counters.
module qupls_decode_seq
    import QuplsPkg::*;
#(
    parameter int DEPTH   = 8,
    parameter int MAX_PFX = 5
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            flush,
    input  logic                            in_valid,
    output logic                            in_ready,
    input  ex_instruction_t                 in_ins,
    input  logic                            in_pfx,
    input  logic                            in_idle,
    input  logic                            dec_ready,
    output logic                            dec_en,
    output ex_instruction_t [QUPLS_WIN-1:0] dec_instr,
    output logic [2:0]                      dec_npfx,
    output logic                            err_orphan
`ifdef QUPLS_DECSEQ_STATS_EN
    ,
    output logic [31:0]                     stat_issued,
    output logic [31:0]                     stat_stall
`endif
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    ex_instruction_t mem_q [DEPTH];
    logic [DEPTH-1:0] pfx_q;
    logic [PW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q, count_d;

    decseq_state_t state_q, state_d;
    logic [2:0]    hold_n_q;

    logic                            dec_en_q, err_orphan_q;
    logic [2:0]                      dec_npfx_q;
    ex_instruction_t [QUPLS_WIN-1:0] dec_instr_q, dec_instr_d;

    ex_instruction_t [QUPLS_WIN-1:0] win;
    logic [QUPLS_WIN-1:0]            win_pfx;
    logic [2:0]                      scan_n, win_n;
    logic                            scan_complete, scan_orphan;

    logic          push, issue, drop, go_hold;
    logic [CW-1:0] pop_n;

    always_comb begin
        for (int j = 0; j < QUPLS_WIN; j++) begin
            win[j]     = mem_q[rd_ptr_q + PW'(j)];
            win_pfx[j] = pfx_q[rd_ptr_q + PW'(j)];
        end
    end

    qupls_decode_seq_scan #(
        .CW      (CW),
        .MAX_PFX (MAX_PFX)
    ) u_scan (
        .pfx      (win_pfx),
        .count    (count_q),
        .in_idle  (in_idle),
        .n        (scan_n),
        .complete (scan_complete),
        .orphan   (scan_orphan)
    );

    assign in_ready = (count_q != CW'(DEPTH));
    assign push     = in_valid && in_ready && !flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE, S_GATHER: begin
                    if (go_hold)              state_d = S_HOLD;
                    else if (count_d == '0)   state_d = S_IDLE;
                    else                      state_d = S_GATHER;
                end
                S_HOLD: begin
                    if (dec_ready) state_d = (count_d == '0) ? S_IDLE : S_GATHER;
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    // IDLE with a non-empty FIFO scans like GATHER so a word pushed at t can issue at t+2
    always_comb begin
        issue   = 1'b0;
        drop    = 1'b0;
        go_hold = 1'b0;
        pop_n   = '0;
        win_n   = scan_n;
        if (!flush) begin
            case (state_q)
                S_IDLE, S_GATHER: begin
                    if (scan_orphan) begin
                        drop  = 1'b1;
                        pop_n = CW'(1);
                    end else if (scan_complete) begin
                        if (dec_ready) begin
                            issue = 1'b1;
                            pop_n = CW'(scan_n) + CW'(1);
                        end else begin
                            go_hold = 1'b1;
                        end
                    end
                end
                S_HOLD: begin
                    win_n = hold_n_q;
                    if (dec_ready) begin
                        issue = 1'b1;
                        pop_n = CW'(hold_n_q) + CW'(1);
                    end
                end
                default: ;
            endcase
        end
        count_d = count_q + CW'(push) - pop_n;
        for (int j = 0; j < QUPLS_WIN; j++)
            dec_instr_d[j] = (3'(j) <= win_n) ? win[j] : QUPLS_NOP_EXINS;
    end

    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= in_ins;
            pfx_q[wr_ptr_q] <= in_pfx;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            count_q      <= '0;
            hold_n_q     <= '0;
            dec_en_q     <= 1'b0;
            err_orphan_q <= 1'b0;
            dec_npfx_q   <= '0;
            dec_instr_q  <= {QUPLS_WIN{QUPLS_NOP_EXINS}};
        end else begin
            dec_en_q     <= issue;
            err_orphan_q <= drop;
            if (flush) begin
                wr_ptr_q <= '0;
                rd_ptr_q <= '0;
                count_q  <= '0;
            end else begin
                wr_ptr_q <= wr_ptr_q + PW'(push);
                rd_ptr_q <= rd_ptr_q + pop_n[PW-1:0];
                count_q  <= count_d;
            end
            if (go_hold) hold_n_q <= scan_n;
            if (issue) begin
                dec_instr_q <= dec_instr_d;
                dec_npfx_q  <= win_n;
            end
        end
    end

    assign dec_en     = dec_en_q;
    assign err_orphan = err_orphan_q;
    assign dec_npfx   = dec_npfx_q;
    assign dec_instr  = dec_instr_q;

`ifdef QUPLS_DECSEQ_STATS_EN
    logic [31:0] stat_issued_q, stat_stall_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stat_issued_q <= '0;
            stat_stall_q  <= '0;
        end else begin
            if (issue)             stat_issued_q <= stat_issued_q + 32'd1;
            if (state_q == S_HOLD) stat_stall_q  <= stat_stall_q + 32'd1;
        end
    end

    assign stat_issued = stat_issued_q;
    assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_qupls_decode_seq.sv
// Bench for qupls_decode_seq: directed vector table, async-reset abort, random run vs queue model.
module tb_qupls_decode_seq;
    import QuplsPkg::*;

    localparam int DEPTH = 8;

    typedef ex_instruction_t [5:0] win_t;

    logic clk = 1'b0;
    logic rst, flush, in_valid, in_ready, in_pfx, in_idle, dec_ready, dec_en, err_orphan;
    ex_instruction_t in_ins;
    win_t            dec_instr;
    logic [2:0]      dec_npfx;
`ifdef QUPLS_DECSEQ_STATS_EN
    logic [31:0] stat_issued, stat_stall;
`endif

    always #5 clk = ~clk;

    qupls_decode_seq #(.DEPTH(DEPTH), .MAX_PFX(5)) dut (
        .clk        (clk),
        .rst        (rst),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_ins     (in_ins),
        .in_pfx     (in_pfx),
        .in_idle    (in_idle),
        .dec_ready  (dec_ready),
        .dec_en     (dec_en),
        .dec_instr  (dec_instr),
        .dec_npfx   (dec_npfx),
        .err_orphan (err_orphan)
`ifdef QUPLS_DECSEQ_STATS_EN
        ,
        .stat_issued (stat_issued),
        .stat_stall  (stat_stall)
`endif
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string name, input logic [191:0] act, input logic [191:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // ---------------- reference model: a plain word queue ----------------
    typedef struct {
        ex_instruction_t ins;
        logic            p;
    } word_t;

    word_t       mq[$];
    bit          m_hold;
    int          m_hn;
    logic        m_en, m_err;
    logic [2:0]  m_npfx;
    win_t        m_win;
    int unsigned m_issued, m_stall;

    function automatic win_t nop_win();
        win_t w;
        for (int j = 0; j < 6; j++) w[j] = QUPLS_NOP_EXINS;
        return w;
    endfunction

    task automatic m_reset();
        mq.delete();
        m_hold   = 0;
        m_hn     = 0;
        m_en     = 0;
        m_err    = 0;
        m_npfx   = 0;
        m_win    = nop_win();
        m_issued = 0;
        m_stall  = 0;
    endtask

    task automatic m_issue(input int n);
        for (int j = 0; j < 6; j++) m_win[j] = (j <= n) ? mq[j].ins : QUPLS_NOP_EXINS;
        m_npfx = 3'(n);
        m_en   = 1;
        m_issued++;
        for (int j = 0; j <= n; j++) void'(mq.pop_front());
    endtask

    task automatic m_cycle(input logic v, input ex_instruction_t ins, input logic p,
                           input logic idle, input logic rdy, input logic fl);
        bit    can_push;
        int    n;
        bit    complete;
        word_t w;
        can_push = (mq.size() < DEPTH);
        m_en  = 0;
        m_err = 0;
        if (m_hold) m_stall++;
        if (fl) begin
            mq.delete();
            m_hold = 0;
        end else begin
            if (m_hold) begin
                if (rdy) begin
                    m_issue(m_hn);
                    m_hold = 0;
                end
            end else if (mq.size() > 0) begin
                if (mq[0].p) begin
                    void'(mq.pop_front());
                    m_err = 1;
                end else begin
                    n = 0;
                    while (n < 5 && n + 1 < mq.size() && mq[n+1].p) n++;
                    complete = (mq.size() > n + 1) || (n == 5) || (idle && mq.size() == n + 1);
                    if (complete) begin
                        if (rdy) m_issue(n);
                        else begin
                            m_hold = 1;
                            m_hn   = n;
                        end
                    end
                end
            end
            if (v && can_push) begin
                w.ins = ins;
                w.p   = p;
                mq.push_back(w);
            end
        end
    endtask

    task automatic step(input logic v, input logic [31:0] ins, input logic p,
                        input logic idle, input logic rdy, input logic fl);
        in_valid  = v;
        in_ins    = ins;
        in_pfx    = p;
        in_idle   = idle;
        dec_ready = rdy;
        flush     = fl;
        m_cycle(v, ins, p, idle, rdy, fl);
        @(posedge clk);
        #1;
        chk("dec_en", 192'(dec_en), 192'(m_en));
        chk("err_orphan", 192'(err_orphan), 192'(m_err));
        chk("in_ready", 192'(in_ready), 192'(mq.size() != DEPTH));
        chk("dec_npfx", 192'(dec_npfx), 192'(m_npfx));
        chk("dec_instr", dec_instr, m_win);
`ifdef QUPLS_DECSEQ_STATS_EN
        chk("stat_issued", 192'(stat_issued), 192'(m_issued));
        chk("stat_stall", 192'(stat_stall), 192'(m_stall));
`endif
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        v;
        logic [31:0] ins;
        logic        p, idle, rdy, fl;
        logic        en;
        logic [2:0]  npfx;
        logic [31:0] w0;
        logic        err, inr;
    } vec_t;

    vec_t tab[$];

    function automatic vec_t mk(input logic v, input logic [31:0] ins, input logic p,
                                input logic idle, input logic rdy, input logic fl,
                                input logic en, input logic [2:0] npfx, input logic [31:0] w0,
                                input logic err, input logic inr);
        vec_t r;
        r.v = v; r.ins = ins; r.p = p; r.idle = idle; r.rdy = rdy; r.fl = fl;
        r.en = en; r.npfx = npfx; r.w0 = w0; r.err = err; r.inr = inr;
        return r;
    endfunction

    initial begin
        logic [31:0] NOP, A, B, A2, P1, P2, B2, P0, A3, B3, A4, E0, F0;
        NOP = QUPLS_NOP_EXINS;
        A  = 32'h1000_0001; B  = 32'h1000_0002; A2 = 32'h1000_0003; B2 = 32'h1000_0004;
        A3 = 32'h1000_0005; B3 = 32'h1000_0006; A4 = 32'h1000_0007;
        P0 = 32'h2000_0000; P1 = 32'h2000_0001; P2 = 32'h2000_0002;
        E0 = 32'h5000_0000; F0 = 32'h6000_0000;

        // A, B: A issues once B is visible, B waits for in_idle
        tab.push_back(mk(1, A,  0, 0, 1, 0, 0, 0, NOP, 0, 1));
        tab.push_back(mk(1, B,  0, 0, 1, 0, 0, 0, NOP, 0, 1));
        tab.push_back(mk(0, 0,  0, 0, 1, 0, 1, 0, A,   0, 1));
        tab.push_back(mk(0, 0,  0, 0, 1, 0, 0, 0, A,   0, 1));
        tab.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, B,   0, 1));
        // A2, P1, P2, B2: one window with two postfixes
        tab.push_back(mk(1, A2, 0, 0, 1, 0, 0, 0, B,   0, 1));
        tab.push_back(mk(1, P1, 1, 0, 1, 0, 0, 0, B,   0, 1));
        tab.push_back(mk(1, P2, 1, 0, 1, 0, 0, 0, B,   0, 1));
        tab.push_back(mk(1, B2, 0, 0, 1, 0, 0, 0, B,   0, 1));
        tab.push_back(mk(0, 0,  0, 0, 1, 0, 1, 2, A2,  0, 1));
        tab.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, B2,  0, 1));
        // orphan postfix P0 then A3, B3
        tab.push_back(mk(1, P0, 1, 0, 1, 0, 0, 0, B2,  0, 1));
        tab.push_back(mk(1, A3, 0, 0, 1, 0, 0, 0, B2,  1, 1));
        tab.push_back(mk(1, B3, 0, 0, 1, 0, 0, 0, B2,  0, 1));
        tab.push_back(mk(0, 0,  0, 0, 1, 0, 1, 0, A3,  0, 1));
        tab.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, B3,  0, 1));
        // A4 + five postfixes held while dec_ready is low
        tab.push_back(mk(1, A4, 0, 0, 0, 0, 0, 0, B3,  0, 1));
        for (int k = 1; k <= 5; k++)
            tab.push_back(mk(1, 32'h3000_0000 + k, 1, 0, 0, 0, 0, 0, B3, 0, 1));
        for (int k = 0; k < 4; k++)
            tab.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, B3, 0, 1));
        tab.push_back(mk(0, 0,  0, 0, 1, 0, 1, 5, A4,  0, 1));
        // fill to DEPTH with dec_ready low, then drain while pushing
        for (int k = 0; k < 7; k++)
            tab.push_back(mk(1, 32'h4000_0000 + k, 0, 0, 0, 0, 0, 5, A4, 0, 1));
        tab.push_back(mk(1, 32'h4000_0007, 0, 0, 0, 0, 0, 5, A4, 0, 0));
        tab.push_back(mk(1, 32'h4000_0008, 0, 0, 0, 0, 0, 5, A4, 0, 0));
        tab.push_back(mk(1, 32'h4000_0008, 0, 0, 1, 0, 1, 0, 32'h4000_0000, 0, 1));
        tab.push_back(mk(1, 32'h4000_0008, 0, 0, 1, 0, 1, 0, 32'h4000_0001, 0, 1));
        // flush with a push in the same cycle, then a normal issue
        tab.push_back(mk(1, E0, 0, 0, 1, 1, 0, 0, 32'h4000_0001, 0, 1));
        tab.push_back(mk(1, F0, 0, 1, 1, 0, 0, 0, 32'h4000_0001, 0, 1));
        tab.push_back(mk(0, 0,  0, 1, 1, 0, 1, 0, F0,  0, 1));

        rst = 1'b1; flush = 0; in_valid = 0; in_ins = '0; in_pfx = 0; in_idle = 0; dec_ready = 0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk("rst_dec_en", 192'(dec_en), 192'(0));
        chk("rst_err", 192'(err_orphan), 192'(0));
        chk("rst_npfx", 192'(dec_npfx), 192'(0));
        chk("rst_instr", dec_instr, nop_win());
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_in_ready", 192'(in_ready), 192'(1));

        foreach (tab[i]) begin
            step(tab[i].v, tab[i].ins, tab[i].p, tab[i].idle, tab[i].rdy, tab[i].fl);
            chk($sformatf("tab%0d_en", i), 192'(dec_en), 192'(tab[i].en));
            chk($sformatf("tab%0d_npfx", i), 192'(dec_npfx), 192'(tab[i].npfx));
            chk($sformatf("tab%0d_w0", i), 192'(dec_instr[0]), 192'(tab[i].w0));
            chk($sformatf("tab%0d_err", i), 192'(err_orphan), 192'(tab[i].err));
            chk($sformatf("tab%0d_rdy", i), 192'(in_ready), 192'(tab[i].inr));
        end

        // async reset in the middle of an incomplete window: no partial issue
        step(1, 32'h7000_0001, 0, 0, 1, 0);
        step(1, 32'h7000_0002, 1, 0, 1, 0);
        #2 rst = 1'b1;
        #1;
        chk("arst_dec_en", 192'(dec_en), 192'(0));
        chk("arst_in_ready", 192'(in_ready), 192'(1));
        chk("arst_instr", dec_instr, nop_win());
        chk("arst_npfx", 192'(dec_npfx), 192'(0));
        m_reset();
        #1 rst = 1'b0;
        step(0, 0, 0, 1, 1, 0);
        chk("arst_no_issue", 192'(dec_en), 192'(0));

        // random traffic against the queue model
        for (int i = 0; i < 2000; i++) begin
            step($urandom_range(0, 99) < 70, $urandom, $urandom_range(0, 99) < 35,
                 $urandom_range(0, 99) < 15, $urandom_range(0, 99) < 65,
                 $urandom_range(0, 99) < 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
